// File: rtl/ysyx_220053_rf_pkg.sv
// ysyx_220053_rf_pkg: shared constants, register-address type and packed-port slice helper
package ysyx_220053_rf_pkg;
  localparam int RF_AW = 5;
  localparam int REG_ZERO = 0;
  localparam int DEPTH = 2 ** RF_AW;
  typedef logic [RF_AW-1:0] reg_addr_t;
  function automatic int slice_off(input int idx, input int w);
    return idx * w;
  endfunction
endpackage

// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: read/issue/write-back bus of the register file
// master: decode/write-back side (drives addresses, issue, write-back)
// slave:  register file (returns read data, ready flags, iss_ready, pending_cnt)
interface regfile_scoreboard_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int NR_RD = 2
);
  logic [NR_RD*ADDR_WIDTH-1:0] rd_addr;
  logic [NR_RD*DATA_WIDTH-1:0] rd_data;
  logic [NR_RD-1:0] rd_ready;
  logic iss_valid;
  logic [ADDR_WIDTH-1:0] iss_rd;
  logic iss_ready;
  logic wb_en;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [ADDR_WIDTH:0] pending_cnt;
  modport master (
    output rd_addr, iss_valid, iss_rd, wb_en, wb_addr, wb_data,
    input rd_data, rd_ready, iss_ready, pending_cnt
  );
  modport slave (
    input rd_addr, iss_valid, iss_rd, wb_en, wb_addr, wb_data,
    output rd_data, rd_ready, iss_ready, pending_cnt
  );
endinterface

// File: rtl/ysyx_220053_rf_read_port.sv
// ysyx_220053_rf_read_port: one combinational read port (x0 zero, optional write bypass, ready)
// in: addr, rf_data (array word at addr), busy (scoreboard bit at addr), wb_en/wb_addr/wb_data
// out: data, ready
// YSYX_220053_REGFILE_BYPASS_EN forwards a same-cycle write-back to the port.
module ysyx_220053_rf_read_port #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] rf_data,
  input  logic                  busy,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  ready
);
  logic zero;
  assign zero = addr == '0;
`ifdef YSYX_220053_REGFILE_BYPASS_EN
  logic byp;
  assign byp = wb_en && wb_addr == addr && !zero;
  assign data = zero ? '0 : byp ? wb_data : rf_data;
  assign ready = zero || byp || !busy;
`else
  logic unused_wb;
  assign unused_wb = ^{wb_en, wb_addr, wb_data};
  assign data = zero ? '0 : rf_data;
  assign ready = zero || !busy;
`endif
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: integer register file with per-register pending-write scoreboard
// ports: clk, rst (sync, active-high), bus (regfile_scoreboard_if.slave: NR_RD read ports,
// issue handshake, write-back port, pending_cnt). Optional YSYX_220053_REGFILE_BYPASS_EN.
module regfile_scoreboard
  import ysyx_220053_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_AW,
  parameter int DATA_WIDTH = 64,
  parameter int NR_RD = 2
) (
  input logic clk,
  input logic rst,
  regfile_scoreboard_if.slave bus
);
  localparam int NREG = 2 ** ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] rf [NREG];
  logic [NREG-1:0] busy, set_mask, clr_mask;
  logic [ADDR_WIDTH:0] cnt;
  logic wb_live, iss_fire, clr_fire;
  assign wb_live = bus.wb_en && bus.wb_addr != ADDR_WIDTH'(REG_ZERO);
  assign bus.iss_ready = bus.iss_rd == ADDR_WIDTH'(REG_ZERO) || !busy[bus.iss_rd] ||
                         (bus.wb_en && bus.wb_addr == bus.iss_rd);
  assign iss_fire = bus.iss_valid && bus.iss_ready && bus.iss_rd != ADDR_WIDTH'(REG_ZERO);
  assign clr_fire = wb_live && busy[bus.wb_addr];
  assign set_mask = iss_fire ? NREG'(1) << bus.iss_rd : '0;
  assign clr_mask = clr_fire ? NREG'(1) << bus.wb_addr : '0;
  assign bus.pending_cnt = cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
      cnt <= '0;
      for (int j = 0; j < NREG; j++) rf[j] <= '0;
    end else begin
      busy <= ((busy & ~clr_mask) | set_mask) & ~NREG'(1);
      cnt <= cnt + (ADDR_WIDTH+1)'(iss_fire) - (ADDR_WIDTH+1)'(clr_fire);
      if (wb_live) rf[bus.wb_addr] <= bus.wb_data;
    end
  end
  genvar i;
  generate
    for (i = 0; i < NR_RD; i++) begin : g_rd
      logic [ADDR_WIDTH-1:0] a;
      assign a = bus.rd_addr[slice_off(i, ADDR_WIDTH) +: ADDR_WIDTH];
      ysyx_220053_rf_read_port #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_port (
        .addr(a),
        .rf_data(rf[a]),
        .busy(busy[a]),
        .wb_en(bus.wb_en),
        .wb_addr(bus.wb_addr),
        .wb_data(bus.wb_data),
        .data(bus.rd_data[slice_off(i, DATA_WIDTH) +: DATA_WIDTH]),
        .ready(bus.rd_ready[i])
      );
    end
  endgenerate
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: queued-expectation scoreboard bench against an array/flag reference model
module tb_regfile_scoreboard;
  localparam int AW = 5;
  localparam int DW = 64;
  localparam int NR = 2;
`ifdef YSYX_220053_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct {
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [1:0] rdy;
    logic irdy;
    logic [AW:0] cnt;
    string tag;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  regfile_scoreboard_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_RD(NR)) bus ();
  regfile_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_RD(NR)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  logic [DW-1:0] rf_m [32];
  bit busy_m [32];
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  task automatic check(input string name, input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%s]: got %h, expected %h", name, tag, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      check("rd_data0", e.tag, bus.rd_data[DW-1:0], e.d0);
      check("rd_data1", e.tag, bus.rd_data[2*DW-1:DW], e.d1);
      check("rd_ready", e.tag, DW'(bus.rd_ready), DW'(e.rdy));
      check("iss_ready", e.tag, DW'(bus.iss_ready), DW'(e.irdy));
      check("pending_cnt", e.tag, DW'(bus.pending_cnt), DW'(e.cnt));
    end
  end
  function automatic void model_read(input int a, input bit we, input int wa, input logic [DW-1:0] wd,
                                     output logic [DW-1:0] d, output logic r);
    if (a == 0) begin d = '0; r = 1'b1; end
    else if (BYP && we && wa == a) begin d = wd; r = 1'b1; end
    else begin d = rf_m[a]; r = !busy_m[a]; end
  endfunction
  task automatic drive(input bit r, input int a0, input int a1, input bit iv, input int ir,
                       input bit we, input int wa, input logic [DW-1:0] wd, input bit chk, input string tag);
    exp_t e;
    int busy_cnt;
    bit irdy;
    rst = r;
    bus.rd_addr = {AW'(a1), AW'(a0)};
    bus.iss_valid = iv;
    bus.iss_rd = AW'(ir);
    bus.wb_en = we;
    bus.wb_addr = AW'(wa);
    bus.wb_data = wd;
    model_read(a0, we, wa, wd, e.d0, e.rdy[0]);
    model_read(a1, we, wa, wd, e.d1, e.rdy[1]);
    irdy = ir == 0 || !busy_m[ir] || (we && wa == ir);
    busy_cnt = 0;
    foreach (busy_m[k]) busy_cnt += int'(busy_m[k]);
    e.irdy = irdy;
    e.cnt = (AW+1)'(busy_cnt);
    e.tag = tag;
    if (chk) q.push_back(e);
    @(posedge clk);
    if (r) begin
      foreach (rf_m[k]) begin rf_m[k] = '0; busy_m[k] = 1'b0; end
    end else begin
      if (we && wa != 0) begin rf_m[wa] = wd; busy_m[wa] = 1'b0; end
      if (iv && irdy && ir != 0) busy_m[ir] = 1'b1;
    end
    #1;
  endtask
  initial begin
    foreach (rf_m[k]) begin rf_m[k] = '0; busy_m[k] = 1'b0; end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, "init");
    drive(1, 5, 0, 0, 0, 0, 0, 0, 1, "reset_state");
    drive(0, 5, 0, 0, 0, 1, 5, 64'hDEAD, 1, "wb_x5");
    drive(1, 5, 1, 0, 0, 0, 0, 0, 1, "x5_before_rst");
    drive(0, 5, 31, 0, 0, 0, 0, 0, 1, "x5_after_rst");
    drive(0, 7, 0, 1, 7, 0, 0, 0, 1, "raw_issue");
    drive(0, 7, 0, 0, 0, 0, 0, 0, 1, "raw_busy");
    drive(0, 7, 0, 0, 0, 1, 7, 64'h1234, 1, "raw_wb");
    drive(0, 7, 0, 0, 0, 0, 0, 0, 1, "raw_after");
    drive(0, 3, 0, 1, 3, 0, 0, 0, 1, "waw_issue");
    drive(0, 3, 0, 1, 3, 0, 0, 0, 1, "waw_refused");
    drive(0, 3, 0, 1, 3, 1, 3, 64'hAB, 1, "waw_wb_same");
    drive(0, 3, 0, 0, 0, 0, 0, 0, 1, "waw_after");
    drive(0, 0, 3, 1, 0, 1, 0, 64'hFFFF, 1, "x0_wb_issue");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, "x0_read");
    drive(0, 0, 0, 0, 0, 1, 3, 64'hCD, 1, "clear_x3");
    drive(0, 1, 2, 1, 1, 0, 0, 0, 1, "iss_x1");
    drive(0, 1, 2, 1, 2, 0, 0, 0, 1, "iss_x2");
    drive(0, 1, 4, 1, 4, 1, 1, 64'h11, 1, "wb_x1_iss_x4");
    drive(0, 1, 4, 0, 0, 0, 0, 0, 1, "rd_x1_x4");
    drive(0, 1, 2, 0, 0, 0, 0, 0, 1, "rd_x1_x2");
    drive(0, 9, 2, 0, 0, 1, 9, 64'h55, 1, "wb_untracked");
    drive(0, 9, 2, 1, 10, 0, 0, 0, 1, "rd_x9_iss_x10");
    drive(1, 10, 2, 0, 0, 0, 0, 0, 1, "rst_mid");
    drive(0, 10, 4, 0, 0, 0, 0, 0, 1, "after_rst_mid");
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 9), $urandom_range(0, 9),
            1'($urandom), $urandom_range(0, 9), 1'($urandom), $urandom_range(0, 9),
            {$urandom, $urandom}, 1, "random");
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
    for (int n = 0; n < 4 && q.size() != 0; n++) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d queued, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
